// File: rtl/full_adder_pkg.sv
// Shared types and truth table for the triple-redundant full adder.
// fa_res_t carries one {co,s} result; FA_TRUTH is indexed by {ci,a,b}.
package fa_pkg;

   typedef struct packed {
      logic co;
      logic s;
   } fa_res_t;

   // Entries are {co,s} for index {ci,a,b} = 0..7.
   localparam fa_res_t FA_TRUTH [8] = '{
      2'b00, 2'b01, 2'b01, 2'b10,
      2'b01, 2'b10, 2'b10, 2'b11
   };

endpackage

// File: rtl/full_adder_if.sv
// Operand and result bundle between the full adder and its user.
// master drives a/b/ci and reads results; slave is the adder side.
interface full_adder_if #(
   parameter int CNT_W = 8
);

   logic             a;
   logic             b;
   logic             ci;
   logic             s1;
   logic             co1;
   logic             s2;
   logic             co2;
   logic             s3;
   logic             co3;
   logic             mismatch;
   logic             err_sticky;
   logic [CNT_W-1:0] mm_count;

   modport master (
      output a, b, ci,
      input  s1, co1, s2, co2, s3, co3,
      input  mismatch, err_sticky, mm_count
   );

   modport slave (
      input  a, b, ci,
      output s1, co1, s2, co2, s3, co3,
      output mismatch, err_sticky, mm_count
   );

endinterface

// File: rtl/full_adder_core.sv
// Combinational core: the same full adder written three ways.
// Ports: a, b, ci in; r1 (dataflow), r2 (behavioral), r3 (case) out.
module fa_core
   import fa_pkg::*;
(
   input  logic    a,
   input  logic    b,
   input  logic    ci,
   output fa_res_t r1,
   output fa_res_t r2,
   output fa_res_t r3
);

   logic [1:0] sum2;
   logic       cs_co;
   logic       cs_s;

   assign r1 = '{
      co: (a & b) | (a & ci) | (b & ci),
      s:  a ^ b ^ ci
   };

   // Operands widened first so the carry survives the add.
   always_comb begin
      sum2 = {1'b0, a} + {1'b0, b} + {1'b0, ci};
   end

   assign r2 = '{co: sum2[1], s: sum2[0]};

   always_comb begin
      {cs_co, cs_s} = 2'b00;
      case ({ci, a, b})
         3'b000:  {cs_co, cs_s} = FA_TRUTH[0];
         3'b001:  {cs_co, cs_s} = FA_TRUTH[1];
         3'b010:  {cs_co, cs_s} = FA_TRUTH[2];
         3'b011:  {cs_co, cs_s} = FA_TRUTH[3];
         3'b100:  {cs_co, cs_s} = FA_TRUTH[4];
         3'b101:  {cs_co, cs_s} = FA_TRUTH[5];
         3'b110:  {cs_co, cs_s} = FA_TRUTH[6];
         3'b111:  {cs_co, cs_s} = FA_TRUTH[7];
         default: {cs_co, cs_s} = 2'b00;
      endcase
   end

   assign r3 = '{co: cs_co, s: cs_s};

endmodule

// File: rtl/full_adder.sv
// Registered triple-redundant full adder with cross-check and error count.
// Ports: clk, rst (sync, active-high), bus (full_adder_if.slave).
module full_adder
   import fa_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst,
   full_adder_if.slave  bus
);

   fa_res_t          r1;
   fa_res_t          r2;
   fa_res_t          r3;
   fa_res_t          q1;
   fa_res_t          q2;
   fa_res_t          q3;
   logic             mm_next;
   logic             mm_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   fa_core u_core (
      .a  (bus.a),
      .b  (bus.b),
      .ci (bus.ci),
      .r1 (r1),
      .r2 (r2),
      .r3 (r3)
   );

   always_comb begin
      mm_next = !((r1 == r2) && (r1 == r3));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q1    <= '0;
         q2    <= '0;
         q3    <= '0;
         mm_q  <= 1'b0;
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         q1    <= r1;
         q2    <= r2;
         q3    <= r3;
         mm_q  <= mm_next;
         err_q <= err_q | mm_next;
         // Saturate at all-ones.
         if (mm_next && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.s1         = q1.s;
   assign bus.co1        = q1.co;
   assign bus.s2         = q2.s;
   assign bus.co2        = q2.co;
   assign bus.s3         = q3.s;
   assign bus.co3        = q3.co;
   assign bus.mismatch   = mm_q;
   assign bus.err_sticky = err_q;
   assign bus.mm_count   = cnt_q;

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder (CNT_W=8 and a CNT_W=2 copy).
// Directed truth-table vectors plus reset, fault and saturation sequences.
module tb_full_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   full_adder_if #(.CNT_W(8)) bus ();
   full_adder_if #(.CNT_W(2)) bus2 ();

   full_adder #(.CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   full_adder #(.CNT_W(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic ci;
      logic a;
      logic b;
      logic s;
      logic co;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic drive(input logic ci, input logic a, input logic b);
      bus.ci  = ci;
      bus.a   = a;
      bus.b   = b;
      bus2.ci = ci;
      bus2.a  = a;
      bus2.b  = b;
   endtask

   // Advance one edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_main(input string nm, input logic s, input logic co,
                           input logic mm);
      chk({nm, ".s1"}, int'(bus.s1), int'(s));
      chk({nm, ".co1"}, int'(bus.co1), int'(co));
      chk({nm, ".s2"}, int'(bus.s2), int'(s));
      chk({nm, ".co2"}, int'(bus.co2), int'(co));
      chk({nm, ".s3"}, int'(bus.s3), int'(s));
      chk({nm, ".co3"}, int'(bus.co3), int'(co));
      chk({nm, ".mm"}, int'(bus.mismatch), int'(mm));
   endtask

   task automatic chk_cleared(input string nm);
      chk_main(nm, 1'b0, 1'b0, 1'b0);
      chk({nm, ".err"}, int'(bus.err_sticky), 0);
      chk({nm, ".cnt"}, int'(bus.mm_count), 0);
      chk({nm, ".err2"}, int'(bus2.err_sticky), 0);
      chk({nm, ".cnt2"}, int'(bus2.mm_count), 0);
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

      // Reset held two cycles with all inputs high.
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 2; i++) begin
         step();
         chk_cleared($sformatf("rst%0d", i));
      end
      rst = 1'b0;

      // Exhaustive sweep, one vector per cycle.
      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].ci, tbl[i].a, tbl[i].b);
         step();
         chk_main($sformatf("sweep%0d", i), tbl[i].s, tbl[i].co, 1'b0);
      end
      chk("sweep.err", int'(bus.err_sticky), 0);
      chk("sweep.cnt", int'(bus.mm_count), 0);

      // Back-to-back toggling 000 / 111.
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) begin
            drive(1'b0, 1'b0, 1'b0);
            step();
            chk_main($sformatf("tog%0d", i), 1'b0, 1'b0, 1'b0);
         end else begin
            drive(1'b1, 1'b1, 1'b1);
            step();
            chk_main($sformatf("tog%0d", i), 1'b1, 1'b1, 1'b0);
         end
      end

      // Fault: case-style carry inverted for 3 cycles on input 011.
      drive(1'b0, 1'b1, 1'b1);
      force dut.u_core.cs_co = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("flt%0d.mm", i), int'(bus.mismatch), 1);
         chk($sformatf("flt%0d.co1", i), int'(bus.co1), 1);
         chk($sformatf("flt%0d.co3", i), int'(bus.co3), 0);
         chk($sformatf("flt%0d.err", i), int'(bus.err_sticky), 1);
         chk($sformatf("flt%0d.cnt", i), int'(bus.mm_count), i + 1);
      end
      release dut.u_core.cs_co;
      drive(1'b1, 1'b0, 1'b1);
      step();
      chk_main("post_flt", 1'b0, 1'b1, 1'b0);
      chk("post_flt.err", int'(bus.err_sticky), 1);
      chk("post_flt.cnt", int'(bus.mm_count), 3);
      step();
      chk("post_flt2.err", int'(bus.err_sticky), 1);
      chk("post_flt2.cnt", int'(bus.mm_count), 3);

      // Saturation on the 2-bit counter copy.
      drive(1'b0, 1'b1, 1'b1);
      force dut2.u_core.cs_co = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("sat%0d.mm", i), int'(bus2.mismatch), 1);
         chk($sformatf("sat%0d.cnt", i), int'(bus2.mm_count),
             (i < 3) ? i + 1 : 3);
      end
      release dut2.u_core.cs_co;
      step();
      chk("sat_end.mm", int'(bus2.mismatch), 0);
      chk("sat_end.cnt", int'(bus2.mm_count), 3);
      chk("sat_end.err", int'(bus2.err_sticky), 1);
      chk("sat_end.dut_cnt", int'(bus.mm_count), 3);

      // Mid-sweep reset while err_sticky is set.
      drive(1'b0, 1'b0, 1'b0);
      step();
      chk_main("mid0", 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      step();
      chk_main("mid1", 1'b1, 1'b0, 1'b0);
      chk("mid1.err", int'(bus.err_sticky), 1);
      rst = 1'b1;
      drive(1'b1, 1'b1, 1'b1);
      step();
      chk_cleared("mid_rst");
      rst = 1'b0;
      drive(1'b1, 1'b0, 1'b1);
      step();
      chk_main("resume", 1'b0, 1'b1, 1'b0);
      chk("resume.err", int'(bus.err_sticky), 0);
      chk("resume.cnt", int'(bus.mm_count), 0);
      drive(1'b0, 1'b1, 1'b0);
      step();
      chk_main("resume2", 1'b1, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
